// File: rtl/ethernet_sys_descriptor_mem_arbiter_if.sv
// One master-side port of the descriptor RAM arbiter (Avalon-MM style with lock).
interface ethernet_sys_descriptor_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Handshake: a request (read | write) is held until the cycle where
  // waitrequest is low; that cycle is the transfer. read+write together is a
  // write. readdatavalid pulses for exactly one cycle, the cycle after an
  // accepted read, and qualifies readdata.
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic                lock;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, read, write, lock, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, lock, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ethernet_sys_descriptor_mem_arbiter.sv
// Two-master round-robin arbiter with atomic lock onto one single-port
// descriptor RAM; zero-wait grant, one transfer per cycle.
module ethernet_sys_descriptor_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  ethernet_sys_descriptor_mem_arbiter_if.slave m0,
  ethernet_sys_descriptor_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [1:0]          dbg_lock_state
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_t;

  lock_state_t state, state_nxt;
  logic req0, req1;
  logic grant0, grant1, any_grant;
  logic last_grant;
  logic sel, sel_write;
  logic rd_pending, rd_owner;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // Grant and lock next-state; grants are forced off while reset is high.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    state_nxt = state;
    if (!reset) begin
      case (state)
        LOCKED0: grant0 = req0;
        LOCKED1: grant1 = req1;
        default: begin
          if (req0 && req1) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
        end
      endcase
    end
    case (state)
      UNLOCKED: begin
        if (grant0 && m0.lock)      state_nxt = LOCKED0;
        else if (grant1 && m1.lock) state_nxt = LOCKED1;
      end
      LOCKED0:  if (grant0 && !m0.lock) state_nxt = UNLOCKED;
      LOCKED1:  if (grant1 && !m1.lock) state_nxt = UNLOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
  end

  assign any_grant = grant0 | grant1;
  // With no grant the mux parks on the last granted master.
  assign sel       = grant1 | (~grant0 & last_grant);
  assign sel_write = sel ? m1.write : m0.write;

  assign mem_address    = sel ? m1.address    : m0.address;
  assign mem_byteenable = sel ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = sel ? m1.writedata  : m0.writedata;
  assign mem_chipselect = any_grant;
  assign mem_write      = any_grant & sel_write;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest   = req0 & ~grant0;
  assign m1.waitrequest   = req1 & ~grant1;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_pending & ~rd_owner;
  assign m1.readdatavalid = rd_pending & rd_owner;
  assign dbg_lock_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= UNLOCKED;
      last_grant <= 1'b1;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pending <= any_grant & ~sel_write;
      if (any_grant) begin
        last_grant <= grant1;
        rd_owner   <= grant1;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_sys_descriptor_mem_arbiter.sv
// Vector-table bench for the descriptor RAM arbiter with a RAM model and read scoreboard.
module tb_ethernet_sys_descriptor_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ethernet_sys_descriptor_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  ethernet_sys_descriptor_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect, mem_write, mem_clken;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;
  logic [1:0]          dbg_lock_state;

  ethernet_sys_descriptor_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .m0(m0_if.slave), .m1(m1_if.slave),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .dbg_lock_state(dbg_lock_state)
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (i * 32'h0001_0003);
  endfunction

  // RAM model: registered read, byte-lane writes, initialised on the first clock.
  logic [31:0] ram [1024];
  logic [31:0] mem_rd = 32'h0;
  logic ram_ready = 1'b0;
  assign mem_readdata = mem_rd;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_rd <= ram[mem_address];
      end
    end
  end

  typedef struct {
    bit          rst;
    logic [2:0]  c0;   // {read, write, lock}
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [3:0]  be0;
    logic [2:0]  c1;
    logic [9:0]  a1;
    logic [31:0] d1;
    logic [3:0]  be1;
    logic [3:0]  e;    // {waitrequest0, waitrequest1, chipselect, write}
  } vec_t;

  localparam logic [2:0] N = 3'b000, R = 3'b100, WL = 3'b011, RW = 3'b110;

  logic [31:0] exp_mem [1024];
  logic [32:0] exp_q [$];   // {owner, data}
  int checks = 0;
  int errors = 0;
  vec_t vecs [$];

  function automatic vec_t mk(bit rst, logic [2:0] c0, logic [9:0] a0, logic [31:0] d0,
                              logic [3:0] be0, logic [2:0] c1, logic [9:0] a1,
                              logic [31:0] d1, logic [3:0] be1, logic [3:0] e);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.c1 = c1; v.a1 = a1; v.d1 = d1; v.be1 = be1; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {m0_if.read, m0_if.write, m0_if.lock} = v.c0;
    m0_if.address = v.a0; m0_if.writedata = v.d0; m0_if.byteenable = v.be0;
    {m1_if.read, m1_if.write, m1_if.lock} = v.c1;
    m1_if.address = v.a1; m1_if.writedata = v.d1; m1_if.byteenable = v.be1;
  endtask

  // Pops at most one expected read per cycle; with nothing queued both valids must be low.
  task automatic check_rdv(input int idx);
    logic [32:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdv0", idx, 32'(m0_if.readdatavalid), 32'(!e[32]));
      chk("rdv1", idx, 32'(m1_if.readdatavalid), 32'(e[32]));
      chk("rdata", idx, e[32] ? m1_if.readdata : m0_if.readdata, e[31:0]);
    end else begin
      chk("rdv0_idle", idx, 32'(m0_if.readdatavalid), 32'd0);
      chk("rdv1_idle", idx, 32'(m1_if.readdatavalid), 32'd0);
    end
  endtask

  task automatic accept(input bit owner, input logic [2:0] c, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    if (c[1]) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_q.push_back({owner, exp_mem[a]});
    end
  endtask

  task automatic reset_dut(input int idx);
    reset = 1'b1;
    drive(mk(0, N, 0, 0, 0, N, 0, 0, 0, 0));
    repeat (2) begin
      @(negedge clk);
      chk("rst_cs", idx, 32'(mem_chipselect), 32'd0);
      chk("rst_rdv", idx, 32'({m0_if.readdatavalid, m1_if.readdatavalid}), 32'd0);
    end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic step(input vec_t v, input int idx);
    bit g0, g1;
    if (v.rst) reset_dut(idx);
    drive(v);
    @(negedge clk);
    check_rdv(idx);
    chk("wait0", idx, 32'(m0_if.waitrequest), 32'(v.e[3]));
    chk("wait1", idx, 32'(m1_if.waitrequest), 32'(v.e[2]));
    chk("mem_cs", idx, 32'(mem_chipselect), 32'(v.e[1]));
    chk("mem_we", idx, 32'(mem_write), 32'(v.e[0]));
    g0 = (v.c0[2] | v.c0[1]) & ~v.e[3];
    g1 = (v.c1[2] | v.c1[1]) & ~v.e[2];
    if (g0) accept(1'b0, v.c0, v.a0, v.d0, v.be0);
    if (g1) accept(1'b1, v.c1, v.a1, v.d1, v.be1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);

    // Single read, then idle to collect its data.
    vecs.push_back(mk(1, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));
    vecs.push_back(mk(0, R, 10'h005, 0, 0, N, 0, 0, 0, 4'b0010));
    vecs.push_back(mk(0, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));
    // Continuous dual reads after reset alternate starting with m0.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(i == 0, R, 10'(32'h20 + i), 0, 0, R, 10'(32'h40 + i), 0, 0,
                        (i % 2 == 0) ? 4'b0110 : 4'b1010));
    vecs.push_back(mk(0, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));
    // m1 locked write/read while m0 keeps requesting.
    vecs.push_back(mk(0, R, 10'h008, 0, 0, N, 0, 0, 0, 4'b0010));
    vecs.push_back(mk(0, R, 10'h007, 0, 0, WL, 10'h3FF, 32'h12345678, 4'b0011, 4'b1011));
    vecs.push_back(mk(0, R, 10'h007, 0, 0, N, 0, 0, 0, 4'b1000));
    vecs.push_back(mk(0, R, 10'h007, 0, 0, R, 10'h3FF, 0, 0, 4'b1010));
    vecs.push_back(mk(0, R, 10'h007, 0, 0, N, 0, 0, 0, 4'b0010));
    vecs.push_back(mk(0, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));
    // m0 lock holds off m1 until m0 unlocks.
    vecs.push_back(mk(0, WL, 10'h030, 32'hAAAA5555, 4'hF, N, 0, 0, 0, 4'b0011));
    vecs.push_back(mk(0, N, 0, 0, 0, R, 10'h030, 0, 0, 4'b0100));
    vecs.push_back(mk(0, R, 10'h030, 0, 0, R, 10'h030, 0, 0, 4'b0110));
    vecs.push_back(mk(0, N, 0, 0, 0, R, 10'h030, 0, 0, 4'b0010));
    vecs.push_back(mk(0, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));
    // read+write together is a write; other master reads the new value next cycle.
    vecs.push_back(mk(0, RW, 10'h010, 32'hCAFEF00D, 4'hF, N, 0, 0, 0, 4'b0011));
    vecs.push_back(mk(0, N, 0, 0, 0, R, 10'h010, 0, 0, 4'b0010));
    vecs.push_back(mk(0, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));
    // Back-to-back reads, then a tie after m1 was last.
    vecs.push_back(mk(0, N, 0, 0, 0, R, 10'h005, 0, 0, 4'b0010));
    vecs.push_back(mk(0, N, 0, 0, 0, R, 10'h006, 0, 0, 4'b0010));
    vecs.push_back(mk(0, R, 10'h006, 0, 0, R, 10'h007, 0, 0, 4'b0110));
    // Random single-requester reads.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        vecs.push_back(mk(0, R, 10'($urandom_range(0, 1023)), 0, 0, N, 0, 0, 0, 4'b0010));
      else
        vecs.push_back(mk(0, N, 0, 0, 0, R, 10'($urandom_range(0, 1023)), 0, 0, 4'b0010));
    end
    vecs.push_back(mk(0, N, 0, 0, 0, N, 0, 0, 0, 4'b0000));

    foreach (vecs[i]) step(vecs[i], i);

    // Reset right after an accepted m0 read: its data must never be flagged valid.
    drive(mk(0, R, 10'h005, 0, 0, N, 0, 0, 0, 0));
    @(negedge clk);
    check_rdv(100);
    chk("pre_rst_wait0", 100, 32'(m0_if.waitrequest), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(mk(0, R, 10'h005, 0, 0, R, 10'h006, 0, 0, 0));
    @(negedge clk);
    chk("rst_wait0", 101, 32'(m0_if.waitrequest), 32'd1);
    chk("rst_wait1", 101, 32'(m1_if.waitrequest), 32'd1);
    chk("rst_cs", 101, 32'(mem_chipselect), 32'd0);
    chk("rst_we", 101, 32'(mem_write), 32'd0);
    chk("rst_rdv0", 101, 32'(m0_if.readdatavalid), 32'd0);
    chk("rst_rdv1", 101, 32'(m1_if.readdatavalid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rdv0", 102, 32'(m0_if.readdatavalid), 32'd0);
    chk("post_rst_wait0", 102, 32'(m0_if.waitrequest), 32'd0);
    chk("post_rst_wait1", 102, 32'(m1_if.waitrequest), 32'd1);
    exp_q.delete();
    accept(1'b0, R, 10'h005, 0, 0);
    @(posedge clk); #1;
    drive(mk(0, N, 0, 0, 0, N, 0, 0, 0, 0));
    @(negedge clk);
    check_rdv(103);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ethernet_sys_descriptor_mem_arbiter.md
ETHERNET_SYS_DESCRIPTOR_MEM_ARBITER -- requirements
Module: ethernet_sys_descriptor_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 10, word address width; DATA_W, 32, data width (byteenable width DATA_W/8).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 mX_address  in  ADDR_W  master X word address (X = 0, 1; all mX_ ports exist for both).
REQ-005 mX_read / mX_write  in  1 each  master X read / write request.
REQ-006 mX_lock  in  1  master X requests atomic hold of the memory port.
REQ-007 mX_byteenable  in  DATA_W/8  write byte lanes.
REQ-008 mX_writedata  in  DATA_W  write data.
REQ-009 mX_waitrequest  out  1  master X request not accepted this cycle.
REQ-010 mX_readdata  out  DATA_W  read data.
REQ-011 mX_readdatavalid  out  1  mX_readdata valid this cycle.
REQ-012 mem_address  out  ADDR_W; mem_chipselect, mem_write  out  1; mem_byteenable  out  DATA_W/8; mem_writedata  out  DATA_W; mem_clken  out  1: drive one port of the descriptor RAM.
REQ-013 mem_readdata  in  DATA_W  RAM output; valid the cycle after address is sampled (unregistered output).

Function
REQ-014 Request X active = mX_read | mX_write; read and write asserted together SHALL be treated as a write.
REQ-015 Grant SHALL be combinational from active requests, last_grant register and lock state; at most one grant per cycle.
REQ-016 Single requester SHALL be granted in the same cycle (zero-wait when unlocked).
REQ-017 Both requesting, unlocked: grant the master != last_grant (round-robin).
REQ-018 last_grant SHALL update to the granted master on every accepted transfer.
REQ-019 mX_waitrequest = request X & ~grant X; transfer accepted when request & ~waitrequest.
REQ-020 Granted master's address/byteenable/writedata SHALL pass to mem_*; mem_chipselect = any grant; mem_write = granted master's write; mem_clken constant 1.
REQ-021 No grant: mem_chipselect = 0, mem_write = 0, mem_address holds granted-last value (don't-care).
REQ-022 Accepted read in cycle N: rd_pending and rd_owner registered; mX_readdatavalid = 1 for owner only in cycle N+1; mX_readdata = mem_readdata (both outputs may carry data; valid qualifies).
REQ-023 Back-to-back reads SHALL be accepted every cycle; throughput 1 transfer/cycle total.
REQ-024 Lock FSM states: UNLOCKED, LOCKED0, LOCKED1.
REQ-025 UNLOCKED -> LOCKEDX when a master X transfer is accepted with mX_lock = 1.
REQ-026 LOCKEDX: only master X granted; other master stalled regardless of round-robin.
REQ-027 LOCKEDX -> UNLOCKED when a master X transfer is accepted with mX_lock = 0; lock without request holds state.
REQ-028 Write accepted in cycle N: RAM written at edge ending cycle N; no readdatavalid generated.
REQ-029 Read of an address written in the previous cycle by other master returns new data (port sequential).

Reset
REQ-030 While reset = 1: no grants, mem_chipselect = 0, mem_write = 0, mX_waitrequest = request X, mX_readdatavalid = 0.
REQ-031 On reset assertion: rd_pending = 0, rd_owner = 0, last_grant = 1 (master 0 wins first tie), lock FSM = UNLOCKED; a read accepted the cycle before reset returns no readdatavalid.

Verification
REQ-032 m0 read addr 0x005 alone, RAM[5]=0xDEADBEEF -> m0_waitrequest 0, next cycle m0_readdatavalid 1, data 0xDEADBEEF, m1_readdatavalid 0.
REQ-033 m0,m1 read continuously for 6 cycles after reset -> grants alternate m0,m1,m0,... each readdatavalid pulses every other cycle.
REQ-034 m1 write 0x3FF = 0x12345678 be=4'b0011 lock=1, then m1 read 0x3FF lock=0 while m0 requests throughout -> m0 stalled both cycles, m1 reads 0x????5678 with lower half 0x5678, then m0 granted.
REQ-035 Reset asserted the cycle after an accepted m0 read -> m0_readdatavalid stays 0; after release first tie goes to m0.
REQ-036 m0 asserts read and write together addr 0x010 -> write performed, no readdatavalid.
